// File: rtl/spike_event_encoder_pkg.sv
// Fixed-point word type shared across the spike datapath, plus encoder-local
// event record and the saturating level step helper.
package fp;
   localparam int WORD_LENGTH         = 16;
   localparam int SPIKE_ADDRESS_WIDTH = 8;
   typedef logic signed [WORD_LENGTH-1:0] fpType;
endpackage

package spike_event_encoder_pkg;
   import fp::*;

   typedef struct packed {
      logic                           valid;
      logic [SPIKE_ADDRESS_WIDTH-1:0] address;
      logic                           on_off;
   } spike_evt_t;

   // Two guard bits so a step of any size up to the word range cannot wrap before the clamp.
   function automatic fpType sat_step(fpType lvl, logic up, int step);
      logic signed [WORD_LENGTH+1:0] st;
      logic signed [WORD_LENGTH+1:0] sum;
      logic signed [WORD_LENGTH+1:0] hi;
      logic signed [WORD_LENGTH+1:0] lo;
      st  = (WORD_LENGTH+2)'(step);
      hi  = (WORD_LENGTH+2)'((2 ** (WORD_LENGTH-1)) - 1);
      lo  = -hi - 1;
      sum = $signed({{2{lvl[WORD_LENGTH-1]}}, lvl}) + (up ? st : -st);
      if (sum > hi)      sat_step = hi[WORD_LENGTH-1:0];
      else if (sum < lo) sat_step = lo[WORD_LENGTH-1:0];
      else               sat_step = sum[WORD_LENGTH-1:0];
   endfunction
endpackage

// File: rtl/spike_in_if.sv
// Broadcast spike event bus between encoder and synapses; no backpressure.
interface spike_in_if;
   logic                               valid;
   logic [fp::SPIKE_ADDRESS_WIDTH-1:0] address;
   logic                               on_off;

   modport master (output valid, address, on_off);
   modport slave  (input  valid, address, on_off);
endinterface

// File: rtl/spike_event_encoder_rr_arbiter.sv
// Rotating-priority arbiter: first requester at or above the pointer wins,
// pointer moves just past the winner.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic          grant_valid,
   output logic [IW-1:0] grant_idx
);
   logic [IW-1:0] ptr;
   logic [IW:0]   cand;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
         if (!grant_valid && req[cand[IW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         ptr <= '0;
      else if (advance && grant_valid)
         ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
   end
endmodule

// File: rtl/spike_event_encoder.sv
// Delta-modulation spike encoder: each channel's reconstructed level chases its
// target in STEP increments, one granted event per clock on the shared bus.
module spike_event_encoder
   import fp::*;
   import spike_event_encoder_pkg::*;
#(
   parameter  int         NUM_CHANNELS = 4,
   parameter  logic [7:0] BASE_ADDRESS = 8'h10,
   parameter  int         STEP         = 128,
   parameter  int         THRESHOLD    = 96,
   localparam int         IW           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     sample_valid,
   input  fpType [NUM_CHANNELS-1:0] sample_data,
   spike_in_if.master               spike_out,
   output logic                     busy,
   output logic [15:0]              event_count
);
   localparam logic signed [WORD_LENGTH:0] THR     = (WORD_LENGTH+1)'(THRESHOLD);
   localparam logic signed [WORD_LENGTH:0] NEG_THR = -THR;

   fpType [NUM_CHANNELS-1:0] target;
   fpType [NUM_CHANNELS-1:0] level;
   logic  [NUM_CHANNELS-1:0] req_on;
   logic  [NUM_CHANNELS-1:0] req_off;
   logic  [NUM_CHANNELS-1:0] req;
   logic                     grant_valid;
   logic  [IW-1:0]           grant_idx;
   fpType                    next_level;
   spike_evt_t               evt;

   // One extra bit keeps target - level exact across the full signed range.
   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      logic signed [WORD_LENGTH:0] delta;
      assign delta      = $signed({target[i][WORD_LENGTH-1], target[i]})
                        - $signed({level[i][WORD_LENGTH-1],  level[i]});
      assign req_on[i]  = (delta >= THR);
      assign req_off[i] = (delta <= NEG_THR);
   end

   assign req = (req_on | req_off) & {NUM_CHANNELS{enable}};

   rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .advance     (enable),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign next_level = sat_step(level[grant_idx], req_on[grant_idx], STEP);

   always_ff @(posedge clk) begin
      if (!reset) begin
         target      <= '0;
         level       <= '0;
         evt         <= '0;
         busy        <= 1'b0;
         event_count <= '0;
      end else begin
         if (sample_valid) target <= sample_data;
         busy      <= |(req_on | req_off);
         evt.valid <= grant_valid;
         // address/on_off deliberately hold through idle cycles.
         if (grant_valid) begin
            evt.address        <= BASE_ADDRESS + SPIKE_ADDRESS_WIDTH'(grant_idx);
            evt.on_off         <= req_on[grant_idx];
            level[grant_idx]   <= next_level;
            event_count        <= event_count + 16'd1;
         end
      end
   end

   assign spike_out.valid   = evt.valid;
   assign spike_out.address = evt.address;
   assign spike_out.on_off  = evt.on_off;
endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Transmitter end of the spike event bus: turns per-channel fixed-point input samples into on/off spike events that synapses consume (valid, address, on_off).
- Per channel, tracks a reconstructed level. Emits an "on" event when the target exceeds the level by at least THRESHOLD, and an "off" event when it falls below by at least THRESHOLD. Each event moves the level by STEP.
- Round-robin arbitration across channels; at most one event per clock on the shared bus.

Parameters:
- NUM_CHANNELS, 4, number of input channels (1..16).
- BASE_ADDRESS, 8'h10, address of channel 0; channel i drives BASE_ADDRESS+i (8-bit, wraps mod 256).
- STEP, 128, level increment/decrement per event; must equal the receiving synapse weight magnitude.
- THRESHOLD, 96, event trigger distance; constraint 0 < THRESHOLD and STEP < 2*THRESHOLD (prevents on/off ping-pong).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  1 = events may be emitted; 0 = bus idle, levels hold.
- sample_valid  input  1  strobe: capture sample_data into the channel targets.
- sample_data  input  NUM_CHANNELS x fp::fpType  new per-channel target values (signed).
- spike_out  spike_in_if.master  {valid 1, address 8, on_off 1}  event bus towards synapses.
- busy  output  1  registered; 1 when any channel has a pending request.
- event_count  output  16  registered count of emitted events, wraps at 16'hffff -> 0.

Behaviour:
- Reset (reset==0 at posedge): targets=0, levels=0, rr pointer=0, spike_out.valid=0, address=0, on_off=0, busy=0, event_count=0. A reset mid-stream drops all pending events; valid is 0 in the following cycle.
- Capture: sample_valid high at a posedge loads all targets. A new sample while events are pending overwrites the targets; requests are re-evaluated against the new targets from the next cycle. Pending requests are not queued.
- Request (combinational from registers):
  - delta = target - level, computed at WORD_LENGTH+1 bits signed.
  - req_on when delta >= THRESHOLD; req_off when delta <= -THRESHOLD; mutually exclusive.
- Arbitration: select the first requesting channel, scanning from the rr pointer upward and wrapping. On a grant, pointer <= grant+1 mod NUM_CHANNELS; with no grant, the pointer holds.
- Emission, registered at the posedge after a grant:
  - valid=1, address=BASE_ADDRESS+grant, on_off=1 for req_on and 0 for req_off.
  - The granted channel's level updates at the same edge: +STEP or -STEP, saturated to the fpType range (clamped to max/min, never wraps).
  - event_count increments.
- No grant in a cycle: valid=0 the next cycle; address and on_off hold their last values.
- Latency: sample_valid captured at edge N -> first event valid during the cycle after edge N+1. A single active channel emits back-to-back, one event per cycle.
- Boundary cases:
  - Saturation can leave delta between 0 and THRESHOLD; no further events are emitted.
  - enable=0: no grants, valid=0 next cycle, levels and pointer hold, targets still capture.
  - enable rising: emission resumes the following cycle.
- No backpressure: the bus is broadcast; every valid cycle is a delivered event.

Decomposition:
- Shared fp package: fpType and WORD_LENGTH (existing); add SPIKE_ADDRESS_WIDTH=8.
- spike_in_if: unchanged.
- Sub-module rr_arbiter, parameter N, with ports req[N], advance, grant_valid, grant_idx. Holds the rotating pointer.
- Delta compare and saturating add remain in the top module.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with sample_valid=1 and data=1000 -> valid=0, address=0, busy=0, event_count=0. After release, no events until the next sample.
2. Single channel up/down: ch0 target=256 -> exactly 2 events, {0x10, on}, on consecutive cycles starting 2 edges after capture; then valid=0. Then target=0 -> 2 events {0x10, off}; event_count=4.
3. Fairness: ch0=384, ch2=-256 in one sample -> emission order ch0 on, ch2 off, ch0 on, ch2 off, ch0 on (addresses 0x10, 0x12, 0x10, 0x12, 0x10); then idle with busy=0.
4. Saturation: ch1 target=32767 -> 256 on events. The last event clamps the level to 32767, not 32768 or a wrapped value. No further events; event_count=256.
5. Overwrite mid-stream: ch0 target=1024; after 3 on events, sample ch0=0 -> 3 off events follow, starting from the cycle after capture settles; final level=0.
6. enable and reset mid-operation: drop enable after 1 of 4 pending events -> valid=0 while low; raising enable resumes the remaining 3. Assert reset during a burst -> valid=0 next cycle, levels=0, no resumed events.
